// File: rtl/bidir_pin_pkg.sv
// Shared types and width helpers for the multi-lane bidirectional pin controller.
// Exports: lane_state_t, default parameters, counter width functions.
package bidir_pin_pkg;

  // Per-lane direction FSM states
  typedef enum logic [1:0] {
    ST_IN       = 2'd0,
    ST_TURN_OUT = 2'd1,
    ST_OUT      = 2'd2,
    ST_TURN_IN  = 2'd3
  } lane_state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_TURN_CYCLES = 2;
  localparam int DEF_SYNC_STAGES = 2;

  // Turnaround counter holds TURN_CYCLES-1 at most; keep at least one bit
  // so TURN_CYCLES=1 still elaborates to a legal vector.
  function automatic int tcnt_width(input int turn_cycles);
    return (turn_cycles > 1) ? $clog2(turn_cycles) : 1;
  endfunction

  // Valid counter saturates at SYNC_STAGES, so it must hold that value.
  function automatic int vcnt_width(input int sync_stages);
    return $clog2(sync_stages + 1);
  endfunction

  localparam int DEF_TCNT_W = tcnt_width(DEF_TURN_CYCLES);
  localparam int DEF_VCNT_W = vcnt_width(DEF_SYNC_STAGES);

endpackage

// File: rtl/bidir_pin_lane.sv
// One pin lane: direction FSM with dead-cycle turnaround, output register,
// tri-state driver, input synchronizer, refill-valid counter, edge detect.
// Ports: clk, rst, pin (pad), dir_req, data_out, data_in, in_valid, rise,
// fall, dir_state, busy.
module bidir_pin_lane
  import bidir_pin_pkg::*;
#(
  parameter int TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  inout  wire  pin,
  input  logic dir_req,
  input  logic data_out,
  output logic data_in,
  output logic in_valid,
  output logic rise,
  output logic fall,
  output logic dir_state,
  output logic busy
);

  localparam int TW = tcnt_width(TURN_CYCLES);
  localparam int VW = vcnt_width(SYNC_STAGES);
  localparam logic [TW-1:0] TLOAD = TW'(TURN_CYCLES - 1);
  localparam logic [VW-1:0] VMAX = VW'(SYNC_STAGES);

  lane_state_t state;
  lane_state_t state_nx;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nx;

  logic out_q;
  logic [SYNC_STAGES-1:0] sync;
  logic [VW-1:0] vcnt;
  logic rise_q;
  logic fall_q;

  logic oe;
  logic is_in;
  logic is_turn;
  logic valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IN;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    unique case (state)
      ST_IN: begin
        if (dir_req) begin
          state_nx = ST_TURN_OUT;
          tcnt_nx  = TLOAD;
        end
      end
      ST_TURN_OUT: begin
        // Abort is safe: the driver was never enabled.
        if (!dir_req) begin
          state_nx = ST_IN;
        end else if (tcnt == '0) begin
          state_nx = ST_OUT;
        end else begin
          tcnt_nx = tcnt - 1'b1;
        end
      end
      ST_OUT: begin
        if (!dir_req) begin
          state_nx = ST_TURN_IN;
          tcnt_nx  = TLOAD;
        end
      end
      ST_TURN_IN: begin
        // Must run to completion; dir_req is looked at again in IN.
        if (tcnt == '0) begin
          state_nx = ST_IN;
        end else begin
          tcnt_nx = tcnt - 1'b1;
        end
      end
      default: begin
        state_nx = ST_IN;
        tcnt_nx  = '0;
      end
    endcase
  end

  // Output decode, from the state register only
  always_comb begin
    oe      = 1'b0;
    is_in   = 1'b0;
    is_turn = 1'b0;
    unique case (state)
      ST_IN:       is_in   = 1'b1;
      ST_OUT:      oe      = 1'b1;
      ST_TURN_OUT: is_turn = 1'b1;
      ST_TURN_IN:  is_turn = 1'b1;
      default: begin
        oe      = 1'b0;
        is_in   = 1'b0;
        is_turn = 1'b0;
      end
    endcase
  end

  assign valid = is_in && (vcnt == VMAX);

  // Datapath: output register, synchronizer, valid counter, edge flops
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= 1'b0;
      sync   <= '0;
      vcnt   <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      out_q <= data_out;
      sync  <= {sync[SYNC_STAGES-2:0], pin};
      if (!is_in) begin
        vcnt <= '0;
      end else if (vcnt != VMAX) begin
        vcnt <= vcnt + 1'b1;
      end
      // The edge is registered as the last stage takes the new value, so
      // the pulse lines up with data_in. Requiring valid before the edge
      // suppresses transitions that arrive while the chain refills.
      rise_q <= valid & sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
      fall_q <= valid & ~sync[SYNC_STAGES-2] & sync[SYNC_STAGES-1];
    end
  end

  assign pin       = oe ? out_q : 1'bz;
  assign data_in   = sync[SYNC_STAGES-1];
  assign in_valid  = valid;
  assign rise      = rise_q & valid;
  assign fall      = fall_q & valid;
  assign dir_state = oe;
  assign busy      = is_turn;

endmodule

// File: rtl/bidir_pin_ctrl.sv
// Multi-lane bidirectional pin controller, one instance per GPIO bank.
// Ports: clk, rst, pin[WIDTH], dir_req, data_out, data_in, in_valid, rise,
// fall, dir_state, busy (all WIDTH bits, one bit per lane).
module bidir_pin_ctrl
  import bidir_pin_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] pin,
  input  logic [WIDTH-1:0] dir_req,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] in_valid,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] dir_state,
  output logic [WIDTH-1:0] busy
);

  // Lanes share only clock and reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bidir_pin_lane #(
      .TURN_CYCLES(TURN_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .pin      (pin[i]),
      .dir_req  (dir_req[i]),
      .data_out (data_out[i]),
      .data_in  (data_in[i]),
      .in_valid (in_valid[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .dir_state(dir_state[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_bidir_pin_ctrl.sv
// Directed, table-driven bench for bidir_pin_ctrl (WIDTH=4, TURN=2, SYNC=2).
// The external device drives every lane and yields while the lane drives.
module tb_bidir_pin_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  wire  [W-1:0] pin;
  logic [W-1:0] dir_req = '0;
  logic [W-1:0] data_out = '0;
  logic [W-1:0] data_in;
  logic [W-1:0] in_valid;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] dir_state;
  logic [W-1:0] busy;
  logic [W-1:0] ext_val = '0;

  int checks = 0;
  int errors = 0;

  bidir_pin_ctrl #(
    .WIDTH(W),
    .TURN_CYCLES(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pin      (pin),
    .dir_req  (dir_req),
    .data_out (data_out),
    .data_in  (data_in),
    .in_valid (in_valid),
    .rise     (rise),
    .fall     (fall),
    .dir_state(dir_state),
    .busy     (busy)
  );

  for (genvar i = 0; i < W; i++) begin : g_ext
    assign pin[i] = dir_state[i] ? 1'bz : ext_val[i];
  end

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] dir;
    logic [W-1:0] dout;
    logic [W-1:0] ext;
    logic [W-1:0] di;
    logic [W-1:0] iv;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
    logic [W-1:0] ds;
    logic [W-1:0] bz;
    logic [W-1:0] pv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] d, input logic [3:0] o,
    input logic [3:0] e, input logic [3:0] di, input logic [3:0] iv,
    input logic [3:0] rs, input logic [3:0] fl, input logic [3:0] ds,
    input logic [3:0] bz, input logic [3:0] pv);
    vec_t v;
    v.rst = r;  v.dir = d;  v.dout = o; v.ext = e;
    v.di = di;  v.iv = iv;  v.rs = rs;  v.fl = fl;
    v.ds = ds;  v.bz = bz;  v.pv = pv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [W-1:0] di,
                      input logic [W-1:0] iv, input logic [W-1:0] rs,
                      input logic [W-1:0] fl, input logic [W-1:0] ds,
                      input logic [W-1:0] bz);
    chk({tag, " data_in"}, data_in, di);
    chk({tag, " in_valid"}, in_valid, iv);
    chk({tag, " rise"}, rise, rs);
    chk({tag, " fall"}, fall, fl);
    chk({tag, " dir_state"}, dir_state, ds);
    chk({tag, " busy"}, busy, bz);
  endtask

  initial begin
    // rst dir dout ext | data_in in_valid rise fall dir_state busy pin
    // reset with lane 0 held high externally
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    // lane 0 to output
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
    tbl.push_back(mk(0, 4'h1, 4'h1, 4'h1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1));
    // loopback of a driven 0
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
    // lane 0 release; pin returns to external 1, no rise while refilling
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    // lane 1 one-cycle request: abort from TURN_OUT
    tbl.push_back(mk(0, 4'h2, 4'h0, 4'h1, 4'h1, 4'hD, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    // lane 2 input 0->1->0, 5 cycles apart
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h5, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h5, 4'h5, 4'hF, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h5, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h5, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));

    #2;
    for (int n = 0; n < tbl.size(); n++) begin
      rst      = tbl[n].rst;
      dir_req  = tbl[n].dir;
      data_out = tbl[n].dout;
      ext_val  = tbl[n].ext;
      step();
      outs($sformatf("row%0d", n), tbl[n].di, tbl[n].iv, tbl[n].rs,
           tbl[n].fl, tbl[n].ds, tbl[n].bz);
      if (tbl[n].ds != '0)
        chk($sformatf("row%0d pin", n), pin & tbl[n].ds,
            tbl[n].pv & tbl[n].ds);
    end

    // Lane 3 to OUT driving 1 against an external 0, then reset in OUT
    dir_req  = 4'h8;
    data_out = 4'h8;
    step();
    outs("l3 turn1", 4'h1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h8);
    step();
    outs("l3 turn2", 4'h1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h8);
    step();
    outs("l3 out", 4'h1, 4'h7, 4'h0, 4'h0, 4'h8, 4'h0);
    chk("l3 out pin", pin & 4'h8, 4'h8);
    step();
    step();
    outs("l3 loopback", 4'h9, 4'h7, 4'h0, 4'h0, 4'h8, 4'h0);
    rst = 1'b1;
    step();
    outs("l3 reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst     = 1'b0;
    dir_req = 4'h0;
    step();
    outs("post rst1", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    step();
    outs("post rst2", 4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
